// File: rtl/int_to_fp16_conv_pkg.sv
// Shared float-word definitions for the int-to-float converter and the sqrt stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package int_to_fp16_conv_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 7;
  localparam int FP_W     = 16;
  localparam int EXP_BIAS = 0;

  // 1 sign bit, EXP_W exponent bits, MAN_W stored mantissa bits (hidden 1 implied)
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  localparam fp16_t FP_ZERO = '{sign: 1'b0, exp: '0, man: '0};

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND
  } i2f_state_t;

endpackage

// File: rtl/int_to_fp16_conv_if.sv
// Request/result bundle between the converter and its producer/consumer.
// Latency: none (wiring only).
// Backpressure: none; starts arriving while busy are dropped by the converter.
interface int_to_fp16_conv_if #(
  parameter int INT_W = 16
);
  import int_to_fp16_conv_pkg::*;

  logic             conv_start;
  logic [INT_W-1:0] int_i;
  fp16_t            num_o;
  logic             valid_o;
  logic             busy_o;
  logic             zero_o;
  logic             inexact_o;

  modport master (
    output conv_start, int_i,
    input  num_o, valid_o, busy_o, zero_o, inexact_o
  );

  modport slave (
    input  conv_start, int_i,
    output num_o, valid_o, busy_o, zero_o, inexact_o
  );

endinterface

// File: rtl/int_to_fp16_conv_fp_round_rne.sv
// Round-to-nearest-even of a truncated mantissa, with exponent bump on carry-out.
// Latency: combinational.
// Backpressure: not applicable.
module fp_round_rne
  import int_to_fp16_conv_pkg::*;
(
  input  logic [MAN_W-1:0] mant_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [MAN_W-1:0] mant_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             inexact_o
);

  logic             round_up;
  logic [MAN_W:0]   sum;

  // Increment on guard unless it is an exact tie onto an already-even mantissa;
  // a carry out of the mantissa leaves it all-zero and bumps the exponent.
  always_comb begin
    round_up  = guard_i & (sticky_i | mant_i[0]);
    sum       = {1'b0, mant_i} + {{MAN_W{1'b0}}, round_up};
    mant_o    = sum[MAN_W-1:0];
    exp_o     = exp_i + {{(EXP_W-1){1'b0}}, sum[MAN_W]};
    inexact_o = guard_i | sticky_i;
  end

endmodule

// File: rtl/int_to_fp16_conv.sv
// Integer to 16-bit float converter, one normalisation shift per cycle; I2F_SIGNED_EN selects two's-complement input.
// Latency: zero input 1 edge; otherwise valid_o lz+2 edges after the accepting edge (max INT_W+1).
// Backpressure: none; conv_start is only sampled in IDLE, starts while busy are dropped.
module int_to_fp16_conv
  import int_to_fp16_conv_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  int_to_fp16_conv_if.slave  conv_if
);

  localparam logic [EXP_W-1:0] EXP_TOP     = EXP_W'(INT_W - 1);
  localparam int               GRD_POS     = INT_W - 2 - MAN_W;
  localparam logic [INT_W-1:0] STICKY_MASK = (INT_W'(1) << GRD_POS) - INT_W'(1);

  i2f_state_t       state_q, state_d;
  logic [INT_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic             sign_q, sign_d;
  fp16_t            num_q, num_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             inexact_q, inexact_d;

  logic [INT_W-1:0] abs_in;
  logic             sign_in;
  logic [MAN_W-1:0] rnd_man;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_inexact;

  // Operand magnitude and sign as seen at the load edge
  always_comb begin
`ifdef I2F_SIGNED_EN
    sign_in = conv_if.int_i[INT_W-1];
    abs_in  = sign_in ? (~conv_if.int_i + INT_W'(1)) : conv_if.int_i;
`else
    sign_in = 1'b0;
    abs_in  = conv_if.int_i;
`endif
  end

  fp_round_rne u_round (
    .mant_i    (mag_q[INT_W-2 -: MAN_W]),
    .guard_i   (mag_q[GRD_POS]),
    .sticky_i  (|(mag_q & STICKY_MASK)),
    .exp_i     (exp_cnt_q + EXP_W'(EXP_BIAS)),
    .mant_o    (rnd_man),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  // Next-state and result update: load, shift until the MSB is set, then round once
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_cnt_d = exp_cnt_q;
    sign_d    = sign_q;
    num_d     = num_q;
    valid_d   = 1'b0;
    zero_d    = zero_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: begin
        if (conv_if.conv_start) begin
          if (conv_if.int_i == '0) begin
            num_d     = FP_ZERO;
            zero_d    = 1'b1;
            inexact_d = 1'b0;
            valid_d   = 1'b1;
          end else begin
            mag_d     = abs_in;
            sign_d    = sign_in;
            exp_cnt_d = EXP_TOP;
            state_d   = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[INT_W-1]) begin
          mag_d     = mag_q << 1;
          exp_cnt_d = exp_cnt_q - EXP_W'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        num_d     = '{sign: sign_q, exp: rnd_exp, man: rnd_man};
        zero_d    = 1'b0;
        inexact_d = rnd_inexact;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      exp_cnt_q <= '0;
      sign_q    <= 1'b0;
      num_q     <= FP_ZERO;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_cnt_q <= exp_cnt_d;
      sign_q    <= sign_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      inexact_q <= inexact_d;
    end
  end

  assign conv_if.num_o     = num_q;
  assign conv_if.valid_o   = valid_q;
  assign conv_if.busy_o    = (state_q != IDLE);
  assign conv_if.zero_o    = zero_q;
  assign conv_if.inexact_o = inexact_q;

endmodule

// File: tb/tb_int_to_fp16_conv.sv
// Directed bench for int_to_fp16_conv: encodings, rounding, latency, busy-drop and reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_int_to_fp16_conv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int_to_fp16_conv_if #(.INT_W(16)) conv_if ();

  int_to_fp16_conv #(.INT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .conv_if (conv_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Present a start at the falling edge; returns #1 after the accepting edge
  task automatic issue(input logic [15:0] v);
    @(negedge clk);
    conv_if.conv_start = 1'b1;
    conv_if.int_i      = v;
    @(posedge clk);
    #1;
    conv_if.conv_start = 1'b0;
  endtask

  // Count edges until valid_o, bounded
  task automatic wait_valid(input string tag, input int want_lat);
    int n;
    n = 0;
    while (conv_if.valid_o !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, want_lat);
  endtask

  task automatic check_result(input string tag, input logic [15:0] num,
                              input logic zero, input logic inexact);
    chk({tag, "_num"}, conv_if.num_o, num);
    chk({tag, "_zero"}, conv_if.zero_o, zero);
    chk({tag, "_inexact"}, conv_if.inexact_o, inexact);
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [15:0] num,
                         input logic zero, input logic inexact, input int lat);
    issue(v);
    chk({tag, "_busy"}, conv_if.busy_o, (lat != 0));
    wait_valid(tag, lat);
    check_result(tag, num, zero, inexact);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, conv_if.valid_o, 1'b0);
    chk({tag, "_hold"}, conv_if.num_o, num);
  endtask

  initial begin
    int seen;
    conv_if.conv_start = 1'b0;
    conv_if.int_i      = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_num", conv_if.num_o, 16'h0000);
    chk("rst_valid", conv_if.valid_o, 1'b0);
    chk("rst_busy", conv_if.busy_o, 1'b0);
    chk("rst_zero", conv_if.zero_o, 1'b0);
    chk("rst_inexact", conv_if.inexact_o, 1'b0);
    rst = 1'b1;

    // main encodings and rounding
    convert("c36",   16'd36,  16'h0290, 1'b0, 1'b0, 12);
    convert("c25",   16'd25,  16'h0248, 1'b0, 1'b0, 13);
    convert("c0",    16'd0,   16'h0000, 1'b1, 1'b0, 0);
    convert("c255",  16'd255, 16'h03FF, 1'b0, 1'b0, 10);
    convert("c257",  16'd257, 16'h0400, 1'b0, 1'b1, 9);
    convert("c511",  16'd511, 16'h0480, 1'b0, 1'b1, 9);
    convert("c1",    16'd1,   16'h0000, 1'b0, 1'b0, 17);
`ifdef I2F_SIGNED_EN
    convert("cm36",  16'hFFDC, 16'h8290, 1'b0, 1'b0, 12);
    convert("cmin",  16'h8000, 16'h8780, 1'b0, 1'b0, 2);
    convert("cm1",   16'hFFFF, 16'h8000, 1'b0, 1'b0, 17);
`else
    convert("cffff", 16'hFFFF, 16'h0800, 1'b0, 1'b1, 2);
    convert("c8000", 16'h8000, 16'h0780, 1'b0, 1'b0, 2);
`endif

    // start in the same cycle as valid_o is accepted
    issue(16'd255);
    wait_valid("b2b_a", 10);
    check_result("b2b_a", 16'h03FF, 1'b0, 1'b0);
    conv_if.conv_start = 1'b1;
    conv_if.int_i      = 16'd0;
    @(posedge clk);
    #1;
    conv_if.conv_start = 1'b0;
    chk("b2b_valid", conv_if.valid_o, 1'b1);
    check_result("b2b_b", 16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_pulse", conv_if.valid_o, 1'b0);

    // start held high while busy with a different operand is dropped
    issue(16'd36);
    conv_if.conv_start = 1'b1;
    conv_if.int_i      = 16'd25;
    repeat (5) @(posedge clk);
    #1;
    conv_if.conv_start = 1'b0;
    wait_valid("busy_ign", 7);
    check_result("busy_ign", 16'h0290, 1'b0, 1'b0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (conv_if.valid_o === 1'b1) seen++;
    end
    chk("busy_ign_extra", seen, 0);

    // reset during NORM aborts without a result
    issue(16'd1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_num", conv_if.num_o, 16'h0000);
    chk("abort_valid", conv_if.valid_o, 1'b0);
    chk("abort_busy", conv_if.busy_o, 1'b0);
    chk("abort_zero", conv_if.zero_o, 1'b0);
    chk("abort_inexact", conv_if.inexact_o, 1'b0);
    rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (conv_if.valid_o === 1'b1 || conv_if.busy_o === 1'b1) seen++;
    end
    chk("abort_quiet", seen, 0);
    convert("post_abort", 16'd25, 16'h0248, 1'b0, 1'b0, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
